// File: rtl/line_framer_tx.sv
// line_framer_tx: wraps each line of packed bytes into a packet of sync byte, 16-bit line index, payload and XOR checksum.
module line_framer_tx #(
  parameter int linewidth_px_p = 320,
  parameter int unpacked_width_p = 1,
  parameter int packed_num_p = 8,
  parameter int lines_p = 240,
  parameter logic [7:0] sync_p = 8'hA5
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       valid_i,
  output logic       ready_o,
  input  logic [7:0] data_i,
  output logic       valid_o,
  input  logic       ready_i,
  output logic [7:0] data_o,
  output logic       frame_done_o
);
  localparam int payload_bytes_lp = linewidth_px_p / packed_num_p;
  localparam int cnt_w_lp = payload_bytes_lp > 1 ? $clog2(payload_bytes_lp) : 1;
  if (unpacked_width_p * packed_num_p != 8) begin : g_bad_pack
    $error("unpacked_width_p*packed_num_p must be 8");
  end
  typedef enum logic [2:0] {SYNC, IDX_HI, IDX_LO, PAYLOAD, CSUM} state_e;
  state_e state_q, state_d;
  logic [15:0] line_idx_q, line_idx_d;
  logic [cnt_w_lp-1:0] byte_cnt_q, byte_cnt_d;
  logic [7:0] csum_q, csum_d, data_q, data_d, load_byte;
  logic valid_q, valid_d, last_q, last_d, free, load;
  always_comb begin
    free = ~valid_q | ready_i;
    state_d = state_q;
    line_idx_d = line_idx_q;
    byte_cnt_d = byte_cnt_q;
    csum_d = csum_q;
    ready_o = 1'b0;
    load = 1'b0;
    load_byte = data_q;
    case (state_q)
      SYNC: begin
        load = valid_i & free;
        load_byte = sync_p;
        csum_d = load ? 8'h00 : csum_q;
        state_d = load ? IDX_HI : SYNC;
      end
      IDX_HI: begin
        load = free;
        load_byte = line_idx_q[15:8];
        csum_d = load ? csum_q ^ load_byte : csum_q;
        state_d = load ? IDX_LO : IDX_HI;
      end
      IDX_LO: begin
        load = free;
        load_byte = line_idx_q[7:0];
        csum_d = load ? csum_q ^ load_byte : csum_q;
        state_d = load ? PAYLOAD : IDX_LO;
      end
      PAYLOAD: begin
        ready_o = free;
        load = valid_i & free;
        load_byte = data_i;
        if (load) begin
          csum_d = csum_q ^ data_i;
          byte_cnt_d = byte_cnt_q == cnt_w_lp'(payload_bytes_lp - 1) ? '0 : byte_cnt_q + 1'b1;
          state_d = byte_cnt_q == cnt_w_lp'(payload_bytes_lp - 1) ? CSUM : PAYLOAD;
        end
      end
      CSUM: begin
        load = free;
        load_byte = csum_q;
        if (load) begin
          line_idx_d = line_idx_q == 16'(lines_p - 1) ? 16'h0 : line_idx_q + 16'h1;
          state_d = SYNC;
        end
      end
      default: state_d = SYNC;
    endcase
    data_d = load ? load_byte : data_q;
    valid_d = load | (valid_q & ~ready_i);
    // remembers that the byte sitting in the output register closes the frame
    last_d = load ? (state_q == CSUM && line_idx_q == 16'(lines_p - 1)) : last_q;
  end
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= SYNC;
      line_idx_q <= '0;
      byte_cnt_q <= '0;
      csum_q <= '0;
      data_q <= '0;
      valid_q <= 1'b0;
      last_q <= 1'b0;
    end else begin
      state_q <= state_d;
      line_idx_q <= line_idx_d;
      byte_cnt_q <= byte_cnt_d;
      csum_q <= csum_d;
      data_q <= data_d;
      valid_q <= valid_d;
      last_q <= last_d;
    end
  end
  assign data_o = data_q;
  assign valid_o = valid_q;
  assign frame_done_o = valid_q & ready_i & last_q;
endmodule

// File: tb/tb_line_framer_tx.sv
// tb_line_framer_tx: randomized packet stream checked against a queue-based packet model.
module tb_line_framer_tx;
  logic clk_i = 0, reset_i = 1, valid_i = 0, ready_i = 1;
  logic ready_o, valid_o, frame_done_o;
  logic [7:0] data_i = 0, data_o;
  line_framer_tx #(.linewidth_px_p(16), .lines_p(3)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .valid_i(valid_i), .ready_o(ready_o), .data_i(data_i),
    .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o), .frame_done_o(frame_done_o)
  );
  always #5 clk_i = ~clk_i;
  int errs = 0, checks = 0, xfer_cnt = 0, done_cnt = 0, line_model = 0, log_n = 0, pos, base;
  logic [8:0] exp_q[$];
  logic [7:0] out_log[1024];
  logic [7:0] prev_data;
  bit rdy_rand = 0, prev_hold = 0, xfer, exp_done, exp_rdy;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // packet model: 6-byte packets; next byte to load sits at (transferred + held) mod 6
  always @(negedge clk_i) begin
    if (reset_i) begin
      xfer_cnt = 0;
      prev_hold = 0;
      exp_q.delete();
    end else begin
      pos = (xfer_cnt + int'(valid_o)) % 6;
      exp_rdy = (pos == 3 || pos == 4) && (!valid_o || ready_i);
      chk("ready_o", ready_o, exp_rdy);
      if (prev_hold) begin
        chk("hold_valid", valid_o, 1);
        chk("hold_data", data_o, prev_data);
      end
      xfer = valid_o & ready_i;
      exp_done = xfer && exp_q.size() > 0 && exp_q[0][8];
      chk("frame_done", frame_done_o, exp_done);
      if (xfer) begin
        if (exp_q.size() == 0) begin
          checks++;
          errs++;
          $display("FAIL extra_byte: got %0h expected none", data_o);
        end else begin
          chk("data_o", data_o, exp_q[0][7:0]);
          void'(exp_q.pop_front());
        end
        if (log_n < 1024) out_log[log_n] = data_o;
        log_n++;
        xfer_cnt++;
        if (frame_done_o) done_cnt++;
      end
      prev_hold = valid_o & ~ready_i;
      prev_data = data_o;
    end
  end
  always begin
    @(posedge clk_i);
    #1;
    ready_i = rdy_rand ? 1'($urandom % 2) : 1'b1;
  end
  task automatic push_pkt(input logic [7:0] b0, input logic [7:0] b1);
    logic [7:0] idx = 8'(line_model);
    exp_q.push_back({1'b0, 8'hA5});
    exp_q.push_back({1'b0, 8'h00});
    exp_q.push_back({1'b0, idx});
    exp_q.push_back({1'b0, b0});
    exp_q.push_back({1'b0, b1});
    exp_q.push_back({line_model == 2, idx ^ b0 ^ b1});
    line_model = (line_model + 1) % 3;
  endtask
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    valid_i = 1;
    data_i = b;
    forever begin
      @(negedge clk_i);
      if (ready_o) break;
      if (++n > 200) begin
        checks++;
        errs++;
        $display("FAIL input_accept: got timeout expected ready_o for %0h", b);
        break;
      end
    end
    @(posedge clk_i);
    #1;
    valid_i = 0;
  endtask
  task automatic send_line(input logic [7:0] b0, input logic [7:0] b1, input int gap);
    push_pkt(b0, b1);
    send_byte(b0);
    repeat (gap) begin
      @(posedge clk_i);
      #1;
    end
    send_byte(b1);
  endtask
  task automatic drain();
    int n = 0;
    while ((exp_q.size() > 0 || valid_o) && n < 500) begin
      @(posedge clk_i);
      #1;
      n++;
    end
    if (n >= 500) begin
      checks++;
      errs++;
      $display("FAIL drain: got %0d bytes pending expected 0", exp_q.size());
    end
  endtask
  initial begin
    @(negedge clk_i);
    chk("rst_valid", valid_o, 0);
    chk("rst_ready", ready_o, 0);
    chk("rst_done", frame_done_o, 0);
    chk("rst_data", data_o, 0);
    @(posedge clk_i);
    #1;
    reset_i = 0;
    send_line(8'h12, 8'h34, 0);
    send_line(8'hFF, 8'h0F, 0);
    send_line(8'($urandom), 8'($urandom), 0);
    drain();
    chk("done_after_3", done_cnt, 1);
    send_line(8'($urandom), 8'($urandom), 0);
    drain();
    chk("done_after_4", done_cnt, 1);
    chk("l0_b0", out_log[0], 8'hA5);
    chk("l0_b2", out_log[2], 8'h00);
    chk("l0_b3", out_log[3], 8'h12);
    chk("l0_b4", out_log[4], 8'h34);
    chk("l0_csum", out_log[5], 8'h26);
    chk("l1_sync", out_log[6], 8'hA5);
    chk("l1_idx", out_log[8], 8'h01);
    chk("l1_b3", out_log[9], 8'hFF);
    chk("l1_csum", out_log[11], 8'hF1);
    chk("l3_sync", out_log[18], 8'hA5);
    chk("l3_idx_hi", out_log[19], 8'h00);
    chk("l3_idx_lo", out_log[20], 8'h00);
    push_pkt(8'h12, 8'h77);
    send_byte(8'h12);
    valid_i = 1;
    data_i = 8'h77;
    @(posedge clk_i);
    #1;
    valid_i = 0;
    chk("pre_reset_valid", valid_o, 1);
    reset_i = 1;
    #1;
    chk("async_reset_valid", valid_o, 0);
    line_model = 0;
    repeat (2) @(posedge clk_i);
    #1;
    reset_i = 0;
    base = log_n;
    send_line(8'h55, 8'h66, 0);
    drain();
    chk("rst_l_sync", out_log[base], 8'hA5);
    chk("rst_l_idx", out_log[base + 2], 8'h00);
    chk("rst_l_csum", out_log[base + 5], 8'h33);
    repeat (5) begin
      @(negedge clk_i);
      chk("idle_valid", valid_o, 0);
    end
    @(posedge clk_i);
    #1;
    send_line(8'($urandom), 8'($urandom), 5);
    drain();
    rdy_rand = 1;
    for (int i = 0; i < 30; i++) send_line(8'($urandom), 8'($urandom), $urandom_range(0, 3));
    drain();
    rdy_rand = 0;
    repeat (3) @(posedge clk_i);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/line_framer_tx.md
Name: line_framer_tx

Overview:
- TX-path framer between the packer and the UART transmitter.
- Wraps each image line of packed output bytes into a self-delimiting packet: sync byte, 16-bit line index, payload bytes, XOR checksum.
- The host receiver uses these packets to realign lines and frames after dropped UART bytes.
- AXIS-style valid/ready on both sides; output is registered.

Parameters:
- linewidth_px_p, 320, pixels per image line.
- unpacked_width_p, 1, bits per pixel.
- packed_num_p, 8, pixels per packed byte. unpacked_width_p*packed_num_p must equal 8.
- lines_p, 240, lines per frame; must be ≤ 65536.
- sync_p, 8'hA5, sync byte value.

Ports:
- clk_i  input  1  system clock (25 MHz).
- reset_i  input  1  asynchronous active-high reset.
- valid_i  input  1  packed payload byte valid (from packer).
- ready_o  output  1  framer accepts payload byte.
- data_i  input  8  packed payload byte.
- valid_o  output  1  framed byte valid (to UART s_axis).
- ready_i  input  1  UART accepts byte.
- data_o  output  8  framed byte.
- frame_done_o  output  1  one-cycle pulse when the checksum byte of line lines_p-1 is accepted.

Behaviour:
- Derived: payload_bytes = linewidth_px_p/packed_num_p (40 at defaults). Packet length = payload_bytes+4.
- Reset (async assert, sync release): valid_o=0, data_o=8'h00, ready_o=0, frame_done_o=0, state=SYNC, line_idx=0, byte_cnt=0, csum=0.
- Output register: a byte loads into data_o/valid_o when valid_o=0 or (valid_o & ready_i).
  - data_o and valid_o hold stable while valid_o=1 and ready_i=0.
  - A byte is transferred on valid_o & ready_i.
- FSM states: SYNC, IDX_HI, IDX_LO, PAYLOAD, CSUM.
- SYNC: ready_o=0. Waits for valid_i=1; no header is emitted with no data pending. Loads sync_p when the output register is free → IDX_HI; csum cleared to 0.
- IDX_HI: loads line_idx[15:8] → IDX_LO; csum ^= byte.
- IDX_LO: loads line_idx[7:0] → PAYLOAD; csum ^= byte.
- PAYLOAD:
  - ready_o = ~valid_o | ready_i (combinational from register state).
  - On valid_i & ready_o: data_i loads into data_o, csum ^= data_i, byte_cnt++.
  - After byte payload_bytes-1 is accepted → CSUM, byte_cnt=0.
  - Latency from input accept to valid_o: 1 cycle.
- CSUM: ready_o=0. Loads csum → SYNC.
  - line_idx wraps lines_p-1 → 0; otherwise increments.
  - frame_done_o pulses for one cycle on the handshake that transfers the checksum byte of line lines_p-1.
- Throughput: with valid_i=1 and ready_i=1 continuously, one byte per cycle with no bubbles; each line takes payload_bytes+4 cycles.
- Checksum covers the index bytes and payload bytes, not the sync byte.
- Header and checksum bytes never depend on valid_i once SYNC has been left; gaps in valid_i during PAYLOAD only stall the packet.
- Simultaneous output transfer and new load in the same cycle are legal; the new byte replaces the old with no bubble.
- Reset mid-packet aborts the packet: the partial packet is discarded, and the next packet starts with sync and line_idx=0.
- ready_o is never asserted outside PAYLOAD; input bytes are never dropped or duplicated.

Test Plan:
- Params linewidth_px_p=16, lines_p=3; line 0 input 0x12, 0x34, ready_i=1 → output A5,00,00,12,34,26 on six consecutive transfers; frame_done_o=0.
- Line 1 input 0xFF, 0x0F → output A5,00,01,FF,0F,F1 (01^FF^0F).
- Random ready_i (50% duty) over line 0 → identical byte sequence; data_o stable whenever valid_o=1 & ready_i=0; ready_o=0 throughout the SYNC/IDX/CSUM states.
- Three lines streamed back to back → frame_done_o pulses exactly once, on the CSUM handshake of line index 2. Fourth line header is A5,00,00.
- Assert reset_i after the 0x12 transfer of line 1 → valid_o=0 immediately (async). Next line emits A5,00,00 with the checksum computed fresh.
- valid_i low for 5 cycles between payload bytes with ready_i=1 → header is emitted only after the first valid_i, no bytes are lost, and the checksum is correct.
